adc_capture: RTL and testbench

Upstream stage of the audio path: programs the LTC6912 preamp gain and runs LTC1407A conversions over the shared SPI bus. Each request yields one 12-bit two's-complement sample per channel. Channel A's sample drives the `datos` input of the DAC driver directly. All bus activity is paced by the same `clockenable` bit tick the DAC driver uses.

---
 rtl/adc_capture.sv | 197 +++++++++++++++++++
 tb/tb_adc_capture.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// adc_capture: programs the LTC6912 preamp gain and reads LTC1407A
// sample pairs over a shared SPI bus paced by the clockenable tick.
module adc_capture (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clockenable,
  input  logic        start,
  input  logic        gainload,
  input  logic [7:0]  gain,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        ampcs,
  output logic        ampshdn,
  output logic        adconv,
  output logic [0:11] datos,
  output logic [0:11] datosb,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAIN,
    S_GAINEND,
    S_CONV,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  gain_q, gain_d;
  logic        gpend_q, gpend_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        ampcs_q, ampcs_d;
  logic        adconv_q, adconv_d;
  logic [13:0] cha_q, cha_d;
  logic [13:0] chb_q, chb_d;
  logic [0:11] datos_q, datos_d;
  logic [0:11] datosb_q, datosb_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  // 0-based SCK period inside a frame, and next preamp bit index
  logic [5:0]  per;
  logic [2:0]  gidx;

  assign per  = cnt_q[6:1];
  assign gidx = 3'd6 - cnt_q[3:1];

  // next-state and output decode; everything but DONE waits for a tick
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    gpend_d  = gpend_q;
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    ampcs_d  = ampcs_q;
    adconv_d = adconv_q;
    cha_d    = cha_q;
    chb_d    = chb_q;
    datos_d  = datos_q;
    datosb_d = datosb_q;
    valid_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clockenable) begin
          if (gpend_q) begin
            gpend_d = 1'b0;
            ampcs_d = 1'b0;
            mosi_d  = gain_q[7];
            cnt_d   = '0;
            state_d = S_GAIN;
          end else if (start) begin
            adconv_d = 1'b1;
            state_d  = S_CONV;
          end
        end
      end
      S_GAIN: begin
        if (clockenable) begin
          cnt_d = cnt_q + 7'd1;
          if (!cnt_q[0]) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (cnt_q == 7'd15) begin
              ampcs_d = 1'b1;
              mosi_d  = 1'b0;
              state_d = S_GAINEND;
            end else begin
              mosi_d = gain_q[gidx];
            end
          end
        end
      end
      S_GAINEND: begin
        if (clockenable) begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (clockenable) begin
          adconv_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (clockenable) begin
          cnt_d = cnt_q + 7'd1;
          if (!cnt_q[0]) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (per >= 6'd2 && per <= 6'd15) begin
              cha_d = {cha_q[12:0], miso};
            end
            if (per >= 6'd18 && per <= 6'd31) begin
              chb_d = {chb_q[12:0], miso};
            end
            if (cnt_q == 7'd67) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        datos_d  = cha_q[13:2];
        datosb_d = chb_q[13:2];
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a fresh load wins over the IDLE tick that consumes the old one
    if (gainload) begin
      gain_d  = gain;
      gpend_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // state and output registers; reset schedules a 0x00 preamp frame
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      gain_q   <= 8'h00;
      gpend_q  <= 1'b1;
      cnt_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      ampcs_q  <= 1'b1;
      adconv_q <= 1'b0;
      cha_q    <= '0;
      chb_q    <= '0;
      datos_q  <= '0;
      datosb_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      gpend_q  <= gpend_d;
      cnt_q    <= cnt_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      ampcs_q  <= ampcs_d;
      adconv_q <= adconv_d;
      cha_q    <= cha_d;
      chb_q    <= chb_d;
      datos_q  <= datos_d;
      datosb_q <= datosb_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ampcs   = ampcs_q;
  assign ampshdn = 1'b0;
  assign adconv  = adconv_q;
  assign datos   = datos_q;
  assign datosb  = datosb_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: scoreboard bench for adc_capture with an SPI
// ADC model, preamp frame decoder and directed scenarios.
module tb_adc_capture;

  logic        clock = 1'b0;
  logic        resetn;
  logic        clockenable = 1'b0;
  logic        start;
  logic        gainload;
  logic [7:0]  gain;
  logic        miso;
  logic        sck;
  logic        mosi;
  logic        ampcs;
  logic        ampshdn;
  logic        adconv;
  logic [0:11] datos;
  logic [0:11] datosb;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic stall = 1'b0;
  int div = 0;
  int tickn = 0;
  int nvalid = 0;
  int nconv = 0;
  int ngain = 0;
  int rises = 0;
  int conv_tick[$];

  logic [13:0] adc_a_q[$];
  logic [13:0] adc_b_q[$];
  logic [11:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];
  logic [7:0]  exp_g_q[$];

  adc_capture dut (
    .clock      (clock),
    .resetn     (resetn),
    .clockenable(clockenable),
    .start      (start),
    .gainload   (gainload),
    .gain       (gain),
    .miso       (miso),
    .sck        (sck),
    .mosi       (mosi),
    .ampcs      (ampcs),
    .ampshdn    (ampshdn),
    .adconv     (adconv),
    .datos      (datos),
    .datosb     (datosb),
    .valid      (valid),
    .busy       (busy)
  );

  initial forever #5 clock = ~clock;

  // one tick every 4 clocks unless stalled
  initial begin
    forever begin
      @(negedge clock);
      div = div + 1;
      clockenable = !stall && (div % 4 == 0);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int val(int w);
    case (w)
      0: return nvalid;
      1: return nconv;
      2: return ngain;
      default: return rises;
    endcase
  endfunction

  task automatic wait_for(string nm, int w, int n);
    int k = 0;
    while (val(w) < n && k < 4000) begin
      @(posedge clock);
      k++;
    end
    chk({"timeout_", nm}, 32'(val(w) >= n), 32'd1);
  endtask

  task automatic push_conv(logic [13:0] a, logic [13:0] b,
                           logic [11:0] ea, logic [11:0] eb);
    adc_a_q.push_back(a);
    adc_b_q.push_back(b);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_sck"}, 32'(sck), 32'd0);
    chk({tag, "_mosi"}, 32'(mosi), 32'd0);
    chk({tag, "_ampcs"}, 32'(ampcs), 32'd1);
    chk({tag, "_ampshdn"}, 32'(ampshdn), 32'd0);
    chk({tag, "_adconv"}, 32'(adconv), 32'd0);
    chk({tag, "_datos"}, 32'(datos), 32'd0);
    chk({tag, "_datosb"}, 32'(datosb), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // monitor: ADC model, preamp frame decoder, sample scoreboard
  initial begin
    logic psck, pamp, padc, pval, in_g, in_c, tk;
    logic [7:0]  gb;
    logic [13:0] ca, cb;
    int nb, gt0;
    psck = 0; pamp = 1; padc = 0; pval = 0;
    in_g = 0; in_c = 0; gb = 0; nb = 0; gt0 = 0;
    ca = 0; cb = 0;
    forever begin
      @(posedge clock);
      tk = clockenable;
      #1;
      if (!resetn) begin
        in_g = 0; in_c = 0;
        psck = 0; pamp = 1; padc = 0; pval = 0;
        continue;
      end
      if (tk) tickn++;
      if (pval) chk("valid_one_clock", 32'(valid), 32'd0);
      if (pamp && !ampcs) begin
        in_g = 1; nb = 0; gb = 0; gt0 = tickn;
      end
      if (in_g && sck && !psck) begin
        gb = {gb[6:0], mosi};
        nb++;
      end
      if (in_g && ampcs && !pamp) begin
        in_g = 0;
        ngain++;
        chk("ampcs_low_ticks", 32'(tickn - gt0 + 1), 32'd17);
        chk("gain_bits", 32'(nb), 32'd8);
        if (exp_g_q.size() == 0) begin
          chk("gain_frame_expected", 32'd0, 32'd1);
        end else begin
          chk("gain_word", 32'(gb), 32'(exp_g_q.pop_front()));
        end
      end
      if (adconv && !padc) begin
        nconv++;
        conv_tick.push_back(tickn);
        chk("gain_before_conv", 32'(exp_g_q.size()), 32'd0);
        chk("busy_in_conv", 32'(busy), 32'd1);
        if (adc_a_q.size() == 0) begin
          chk("conv_expected", 32'd0, 32'd1);
          ca = 0; cb = 0;
        end else begin
          ca = adc_a_q.pop_front();
          cb = adc_b_q.pop_front();
        end
        in_c = 1;
        rises = 0;
      end
      if (in_c && sck && !psck) begin
        rises++;
        if (rises >= 3 && rises <= 16) miso = ca[16 - rises];
        else if (rises >= 19 && rises <= 32) miso = cb[32 - rises];
        else miso = 1'b1;
      end
      if (valid && !pval) begin
        nvalid++;
        if (in_c) chk("sck_rises", 32'(rises), 32'd34);
        in_c = 0;
        if (exp_a_q.size() == 0) begin
          chk("sample_expected", 32'd0, 32'd1);
        end else begin
          chk("datos", 32'(datos), 32'(exp_a_q.pop_front()));
          chk("datosb", 32'(datosb), 32'(exp_b_q.pop_front()));
        end
      end
      psck = sck; pamp = ampcs; padc = adconv; pval = valid;
    end
  end

  // directed scenarios
  initial begin
    logic s0, m0;
    int t0, r0;
    resetn = 0; start = 0; gainload = 0; gain = 0; miso = 0;
    repeat (3) @(negedge clock);
    chk_reset_outs("rst");

    exp_g_q.push_back(8'h00);
    @(negedge clock);
    resetn = 1;
    wait_for("gain0", 2, 1);

    @(negedge clock);
    gain = 8'h1A;
    gainload = 1;
    exp_g_q.push_back(8'h1A);
    @(negedge clock);
    gainload = 0;
    wait_for("gain1a", 2, 2);

    push_conv(14'h1ABC, 14'h2001, 12'h6AF, 12'h800);
    push_conv(14'h3FFF, 14'h0000, 12'hFFF, 12'h000);
    @(negedge clock);
    start = 1;
    wait_for("conv2", 1, 2);
    start = 0;
    wait_for("valid2", 0, 2);
    chk("start_to_start", 32'(conv_tick[1] - conv_tick[0]), 32'd70);

    push_conv(14'h0555, 14'h3AAA, 12'h155, 12'hEAA);
    push_conv(14'h2000, 14'h1FFF, 12'h800, 12'h7FF);
    @(negedge clock);
    start = 1;
    wait_for("conv3", 1, 3);
    wait_for("rises3", 3, 20);
    @(negedge clock);
    gain = 8'h5C;
    gainload = 1;
    exp_g_q.push_back(8'h5C);
    @(negedge clock);
    gainload = 0;
    wait_for("conv4", 1, 4);
    start = 0;
    wait_for("valid4", 0, 4);
    chk("gain_frames", 32'(ngain), 32'd3);

    push_conv(14'h1ABC, 14'h2001, 12'h6AF, 12'h800);
    @(negedge clock);
    start = 1;
    wait_for("conv5", 1, 5);
    start = 0;
    wait_for("rises5", 3, 20);
    @(posedge clock);
    #2 stall = 1;
    repeat (3) @(posedge clock);
    #2;
    s0 = sck; m0 = mosi; t0 = tickn; r0 = rises;
    repeat (50) @(posedge clock);
    #2;
    chk("stall_sck", 32'(sck), 32'(s0));
    chk("stall_mosi", 32'(mosi), 32'(m0));
    chk("stall_ticks", 32'(tickn), 32'(t0));
    chk("stall_rises", 32'(rises), 32'(r0));
    stall = 0;
    wait_for("valid5", 0, 5);

    push_conv(14'h3FFF, 14'h3FFF, 12'hFFF, 12'hFFF);
    @(negedge clock);
    start = 1;
    wait_for("conv6", 1, 6);
    start = 0;
    wait_for("rises6", 3, 10);
    @(negedge clock);
    #2 resetn = 0;
    #1 chk_reset_outs("midrst");
    exp_a_q.delete();
    exp_b_q.delete();
    adc_a_q.delete();
    adc_b_q.delete();
    exp_g_q.push_back(8'h00);
    repeat (2) @(negedge clock);
    resetn = 1;

    push_conv(14'h1ABC, 14'h0001, 12'h6AF, 12'h000);
    start = 1;
    wait_for("conv7", 1, 7);
    start = 0;
    wait_for("valid6", 0, 6);
    chk("gain_frames_rst", 32'(ngain), 32'd4);
    chk("exp_left", 32'(exp_a_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
